seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the 8-digit common-anode seven-segment display on the board.
- Sits downstream of the CPU debug taps (ALU result, register file, data memory, PC) at the top level and replaces the single fixed digit drive.
- Shows a 32-bit value as 8 hex digits, with per-digit enable, decimal points, optional leading-zero suppression and an anti-ghosting blank interval.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; 0 is legal and disables blanking.
- NUM_DIGITS, 8, digits scanned; fixed at 8 for this board.

Ports:
- clk  in  1  system clock (undivided board clock).
- rst  in  1  reset, asynchronous, active-high.
- value  in  32  display value; nibble i drives digit i (digit 0 is rightmost).
- load  in  1  single-cycle strobe; captures value, dp_in, digit_en and lz_en into shadow registers.
- dp_in  in  8  decimal point per digit, 1 = lit.
- digit_en  in  8  1 = digit may light; 0 = forced blank.
- lz_en  in  1  1 = suppress leading zeros.
- AN  out  8  anodes, active-low, one-hot-low when driving.
- SEG  out  8  cathodes, active-low; bits 6:0 = g..a, bit 7 = dp.
- frame_start  out  1  one-cycle pulse when the scan enters digit 0.

Behaviour:
- Reset (async): slot counter = 0, digit index = 0, all shadow registers = 0, AN = 8'hFF, SEG = 8'hFF, frame_start = 0.
- Slot counter runs 0..SCAN_DIV-1, then wraps. On wrap the digit index increments modulo 8 (7 -> 0).
- frame_start is registered. It pulses high for exactly one cycle in the cycle after the index changes 7 -> 0. It does not pulse out of reset.
- Shadow registers:
  - Load on any cycle with load=1.
  - New data is used from the next clk edge onward, which can be mid-slot; no tearing protection beyond this is required.
  - Without a load, the display keeps the last captured data indefinitely.
- Digit drive for index i, while slot counter >= BLANK_CYCLES:
  - Digit i is blank if digit_en[i]=0, or if lz_en=1 and i!=0 and shadow nibbles i..7 are all zero.
  - Blank digit: AN = 8'hFF, SEG = 8'hFF.
  - Otherwise: AN bit i = 0 and all other bits = 1; SEG[6:0] = active-low hex pattern of nibble i; SEG[7] = ~dp_in[i].
- Digit 0 is never zero-suppressed, so a value of 0 with lz_en=1 still shows "0".
- While slot counter < BLANK_CYCLES: AN = 8'hFF, SEG = 8'hFF.
- AN and SEG are registered: they reflect counter/index state with 1 cycle latency.
- Hex patterns (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- AN is never driven with more than one bit low, in any cycle including reset release.
- Reset asserted mid-slot: outputs go to 8'hFF immediately (asynchronously). On release, scanning restarts at digit 0, counter 0.
- Counter width: $clog2(SCAN_DIV). No other arithmetic wraps.

Test Plan:
- Bench uses SCAN_DIV=8, BLANK_CYCLES=2 for all scenarios.
- Reset release: AN=FF and SEG=FF during reset. After release, cycles 1-2 are blank. From cycle 3, AN=FE and SEG=1000000 with value=0 loaded and digit_en=FF.
- Load value=32'h89ABCDEF, digit_en=FF, dp=0, lz_en=0, then scan a full frame:
  - AN steps FE, FD, FB ... 7F, one digit per 8 cycles.
  - SEG[6:0] sequence: 0001110 (F), 0000110, 0100001, 1000110, 0000011, 0001000, 0010000, 0000000.
  - frame_start pulses exactly once per 64 cycles.
- Load value=32'h00000A05, lz_en=1: only digits 0-2 light, showing "A05" with digit 1 = "0" (interior zero kept). Load value=0: only digit 0 lights, showing "0".
- digit_en=8'b00000101 with dp_in=8'h04: only digits 0 and 2 drive. Digit 2 has SEG[7]=0; digit 0 has SEG[7]=1.
- Assert rst mid-slot at digit 5: AN=FF in the same cycle, before the next clk edge. After release, the scan resumes at digit 0. Captured data is cleared to 0.
- Check AN on every cycle across all scenarios: each AN is one of FF, FE, FD, FB, F7, EF, DF, BF, 7F.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver.
// Handshake: load is a single-cycle capture strobe with no ready; the driver always accepts it.
interface seg7_scan_driver_if;
    logic [31:0] value;
    logic        load;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        lz_en;
    logic [7:0]  AN;
    logic [7:0]  SEG;
    logic        frame_start;

    modport master (
        output value, load, dp_in, digit_en, lz_en,
        input  AN, SEG, frame_start
    );

    modport slave (
        input  value, load, dp_in, digit_en, lz_en,
        output AN, SEG, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode hex display driver with blanking,
// per-digit enable, decimal points and leading-zero suppression.
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int NUM_DIGITS   = 8
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   value_q, value_d;
    logic [7:0]    dp_q, dp_d;
    logic [7:0]    en_q, en_d;
    logic          lz_q, lz_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_start_q, frame_start_d;

    logic          cnt_wrap;
    logic          run;
    logic [7:0]    upper_zero;
    logic [3:0]    nib;
    logic          digit_blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        cnt_wrap      = (cnt_q == CNT_MAX);
        cnt_d         = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d         = cnt_wrap ? idx_q + 1'b1 : idx_q;
        frame_start_d = cnt_wrap && (idx_q == IDX_MAX);

        value_d = bus.load ? bus.value    : value_q;
        dp_d    = bus.load ? bus.dp_in    : dp_q;
        en_d    = bus.load ? bus.digit_en : en_q;
        lz_d    = bus.load ? bus.lz_en    : lz_q;

        // upper_zero[i] is set when nibbles i..7 are all zero
        run        = 1'b1;
        upper_zero = '0;
        for (int i = 7; i >= 0; i--) begin
            run           = run & (value_q[4*i +: 4] == 4'h0);
            upper_zero[i] = run;
        end

        nib         = value_q[{idx_q, 2'b00} +: 4];
        digit_blank = !en_q[idx_q] || (lz_q && (idx_q != '0) && upper_zero[idx_q]);

        if ((cnt_q < BLANK_V) || digit_blank) begin
            an_d  = 8'hFF;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = {~dp_q[idx_q], hex7(nib)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            value_q       <= '0;
            dp_q          <= '0;
            en_q          <= '0;
            lz_q          <= 1'b0;
            an_q          <= 8'hFF;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            value_q       <= value_d;
            dp_q          <= dp_d;
            en_q          <= en_d;
            lz_q          <= lz_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.AN          = an_q;
    assign bus.SEG         = seg_q;
    assign bus.frame_start = frame_start_q;
endmodule
